// File: rtl/seg_fade_pkg.sv
// seg_fade_pkg
//   Shared definitions for the fading segment chaser: chase-mode and
//   bounce-direction encodings, plus the figure-eight position-to-channel
//   table used when SEG_FADE_FIGURE8_EN is defined.
package seg_fade_pkg;

   typedef enum logic [1:0] {
      MODE_FWD    = 2'b00,
      MODE_REV    = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } chase_mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // Figure-eight lap: positions 0..7 map to channels 0,1,6,4,3,2,6,5.
   // Packed as 4-bit nibbles, position 0 in the least significant nibble.
   localparam logic [31:0] FIG8_MAP = {4'd5, 4'd6, 4'd2, 4'd3,
                                       4'd4, 4'd6, 4'd1, 4'd0};

   function automatic logic [3:0] fig8_channel(input logic [2:0] idx);
      return FIG8_MAP[idx*4 +: 4];
   endfunction

endpackage

// File: rtl/fade_pwm_channel.sv
// fade_pwm_channel
//   One output channel: brightness register with load/decay priority,
//   PWM compare against the shared counter and a registered, polarity
//   adjusted output.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        force brightness to full scale (wins over decay)
//   decay       halve brightness (logical shift right)
//   pwm_cnt     shared free-running PWM counter
//   seg_out     PWM drive, active-low when COMMON_ANODE = 1
module fade_pwm_channel #(
   parameter int BRIGHT_WIDTH = 5,
   parameter int COMMON_ANODE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    decay,
   input  logic [BRIGHT_WIDTH-1:0] pwm_cnt,
   output logic                    seg_out
);

   localparam logic INACTIVE = (COMMON_ANODE != 0);

   logic [BRIGHT_WIDTH-1:0] bright;

   always_ff @(posedge clk) begin
      if (reset) begin
         bright  <= '0;
         seg_out <= INACTIVE;
      end else begin
         if (load) begin
            bright <= '1;
         end else if (decay) begin
            bright <= bright >> 1;
         end
         // Strict compare: brightness 0 never lights, full scale misses one slot.
         seg_out <= (bright > pwm_cnt) ^ INACTIVE;
      end
   end

endmodule

// File: rtl/seg_fade_chaser.sv
// seg_fade_chaser
//   Walks a lit position across NUM_CH channels at a programmable step
//   rate. The visited channel is held at full brightness; every channel
//   decays by halving once per 2^FADE_WIDTH clocks and is rendered by PWM.
//   Optional macro SEG_FADE_FIGURE8_EN: 8-step figure-eight lap through
//   the package table (needs NUM_CH >= 7); otherwise identity mapping.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   en          1 = position advances, 0 = frozen (fade/PWM keep running)
//   speed       step-rate select, larger = slower
//   mode        00 forward, 01 reverse, 10 bounce, 11 hold
//   seg_out     per-channel PWM drive, polarity set by COMMON_ANODE
module seg_fade_chaser #(
   parameter int NUM_CH       = 8,
   parameter int STEP_WIDTH   = 22,
   parameter int SPEED_WIDTH  = 3,
   parameter int FADE_WIDTH   = 20,
   parameter int BRIGHT_WIDTH = 5,
   parameter int COMMON_ANODE = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [SPEED_WIDTH-1:0] speed,
   input  logic [1:0]             mode,
   output logic [NUM_CH-1:0]      seg_out
);

   import seg_fade_pkg::*;

`ifdef SEG_FADE_FIGURE8_EN
   localparam int SEQ_LEN = 8;
   if (NUM_CH < 7) begin : g_fig8_check
      $error("seg_fade_chaser: figure-eight sequence needs NUM_CH >= 7");
   end
`else
   localparam int SEQ_LEN = NUM_CH;
`endif

   localparam int POS_W = $clog2(SEQ_LEN);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(SEQ_LEN - 1);

   // Registered control inputs
   logic [SPEED_WIDTH-1:0] speed_r;
   chase_mode_t            mode_r;
   logic                   en_r;

   logic [STEP_WIDTH-1:0]   step_cnt;
   logic [FADE_WIDTH-1:0]   fade_cnt;
   logic [BRIGHT_WIDTH-1:0] pwm_cnt;
   logic [POS_W-1:0]        pos, pos_nxt;
   dir_t                    dir, dir_nxt;

   logic [STEP_WIDTH-1:0] step_limit;
   logic                  step_evt;
   logic                  move_up;
   logic                  decay;
   logic [CH_W-1:0]       active_ch;

   always_ff @(posedge clk) begin
      speed_r <= speed;
      mode_r  <= chase_mode_t'(mode);
      en_r    <= en;
   end

   assign step_limit = {speed_r, {(STEP_WIDTH - SPEED_WIDTH){1'b1}}};
   // ">=" so a speed decrease that strands step_cnt above the limit steps at once.
   assign step_evt   = (step_cnt >= step_limit);
   assign decay      = (fade_cnt == '0);

   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir;
      move_up = 1'b0;
      // Outside bounce the direction tracks the last mode, so entering
      // bounce from reverse starts downward and from anything else upward.
      if (mode_r != MODE_BOUNCE) begin
         dir_nxt = (mode_r == MODE_REV) ? DIR_DOWN : DIR_UP;
      end
      if (step_evt && en_r) begin
         case (mode_r)
            MODE_FWD: pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            MODE_REV: pos_nxt = (pos == '0) ? POS_LAST : pos - POS_W'(1);
            MODE_BOUNCE: begin
               // A direction pointing off an end (possible right after a
               // mode change) reflects instead of wrapping.
               move_up = ((dir == DIR_UP) && (pos != POS_LAST)) ||
                         ((dir == DIR_DOWN) && (pos == '0));
               pos_nxt = move_up ? pos + POS_W'(1) : pos - POS_W'(1);
               if (pos_nxt == POS_LAST) begin
                  dir_nxt = DIR_DOWN;
               end else if (pos_nxt == '0) begin
                  dir_nxt = DIR_UP;
               end else begin
                  dir_nxt = move_up ? DIR_UP : DIR_DOWN;
               end
            end
            default: pos_nxt = pos;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_cnt <= '0;
         fade_cnt <= '0;
         pwm_cnt  <= '0;
         pos      <= '0;
         dir      <= DIR_UP;
      end else begin
         step_cnt <= step_evt ? '0 : step_cnt + STEP_WIDTH'(1);
         fade_cnt <= fade_cnt + FADE_WIDTH'(1);
         pwm_cnt  <= pwm_cnt + BRIGHT_WIDTH'(1);
         pos      <= pos_nxt;
         dir      <= dir_nxt;
      end
   end

`ifdef SEG_FADE_FIGURE8_EN
   assign active_ch = CH_W'(fig8_channel(3'(pos)));
`else
   assign active_ch = CH_W'(pos);
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      fade_pwm_channel #(
         .BRIGHT_WIDTH(BRIGHT_WIDTH),
         .COMMON_ANODE(COMMON_ANODE)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .load    (active_ch == CH_W'(i)),
         .decay   (decay),
         .pwm_cnt (pwm_cnt),
         .seg_out (seg_out[i])
      );
   end

endmodule
